// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the scheduler state encoding and the trap cause codes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEMWAIT,
        ST_TRAP
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_ILL   = 2'd1;
    localparam logic [1:0] CAUSE_MEMTO = 2'd2;

    // True when an in-flight load writes a register the ID instruction reads.
    // x0 never creates a dependency.
    function automatic logic load_use_hit(
        input logic       id_valid,
        input logic       ex_valid,
        input logic       ex_is_load,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2
    );
        return id_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
               ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_cnt;

    // Count up on inc, sticking at the maximum value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign q = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline.
// Control outputs are combinational from state and inputs.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_ill,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_rd,
    input  logic              ex_redirect,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              bubble_ex,
    output logic              pc_redirect,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [PERF_W-1:0] perf_stall,
    output logic [PERF_W-1:0] perf_flush
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        r_state;
    logic [CW-1:0] r_wait_cnt;
    logic [1:0]    r_cause;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_cause_nxt;
    logic          w_freeze;
    logic          w_load_use;
    logic          w_redir_win;

    assign w_freeze   = mem_req & ~mem_ready;
    assign w_load_use = load_use_hit(id_valid, ex_valid, ex_is_load,
                                     ex_rd, id_rs1, id_rs2);

    // State, wait counter and latched trap cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_cause    <= CAUSE_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
            r_cause    <= w_cause_nxt;
        end
    end

    // Priority hazard resolution and next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        w_cause_nxt = r_cause;
        w_redir_win = 1'b0;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        stall_mem   = 1'b0;
        flush_id    = 1'b0;
        bubble_ex   = 1'b0;
        pc_redirect = 1'b0;

        if (r_state == ST_TRAP) begin
            // Halt the front end; older instructions still drain.
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
            flush_id  = 1'b1;
            stall_ex  = w_freeze;
            stall_mem = w_freeze;
        end else if (w_freeze) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            if (r_state == ST_RUN) begin
                w_state_nxt = ST_MEMWAIT;
                w_cnt_nxt   = CNT_ONE;
            end else if (r_wait_cnt == CNT_MAX) begin
                w_state_nxt = ST_TRAP;
                w_cause_nxt = CAUSE_MEMTO;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_wait_cnt + CNT_ONE;
            end
        end else begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
            if (ex_valid && ex_redirect) begin
                // ID holds a wrong-path instruction; its flags are moot.
                pc_redirect = 1'b1;
                flush_id    = 1'b1;
                bubble_ex   = 1'b1;
                w_redir_win = 1'b1;
            end else if (w_load_use) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (id_valid && id_ill) begin
                // Keep the illegal instruction out of EX.
                stall_if    = 1'b1;
                bubble_ex   = 1'b1;
                w_state_nxt = ST_TRAP;
                w_cause_nxt = CAUSE_ILL;
            end
        end

        // Nothing is stalled or flushed while reset is held.
        if (reset) begin
            stall_if    = 1'b0;
            stall_id    = 1'b0;
            stall_ex    = 1'b0;
            stall_mem   = 1'b0;
            flush_id    = 1'b0;
            bubble_ex   = 1'b0;
            pc_redirect = 1'b0;
            w_redir_win = 1'b0;
        end
    end

    assign trap       = (r_state == ST_TRAP);
    assign trap_cause = r_cause;

    sat_counter #(.W(PERF_W)) u_perf_stall (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_if),
        .q     (perf_stall)
    );

    sat_counter #(.W(PERF_W)) u_perf_flush (
        .clk   (clk),
        .reset (reset),
        .inc   (w_redir_win),
        .q     (perf_flush)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// Small timeout and counter width expose the boundaries.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid, id_ill, ex_valid, ex_is_load, ex_redirect;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          mem_req, mem_ready;
    logic          stall_if, stall_id, stall_ex, stall_mem;
    logic          flush_id, bubble_ex, pc_redirect, trap;
    logic [1:0]    trap_cause;
    logic [PW-1:0] perf_stall, perf_flush;

    int n_chk  = 0;
    int n_fail = 0;

    logic [6:0] ctl;
    assign ctl = {stall_if, stall_id, stall_ex, stall_mem,
                  flush_id, bubble_ex, pc_redirect};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .PERF_W(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_ill      (id_ill),
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .ex_redirect (ex_redirect),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .stall_ex    (stall_ex),
        .stall_mem   (stall_mem),
        .flush_id    (flush_id),
        .bubble_ex   (bubble_ex),
        .pc_redirect (pc_redirect),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid = 0; id_ill = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_redirect = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    // ctl bits: {sif,sid,sex,smem,fid,bex,pcr}
    initial begin
        clr();
        reset = 1;
        tick(); tick();
        check("rst_ctl", 32'(ctl), 32'h00);
        reset = 0;
        #1;
        check("rst_trap", 32'(trap), 0);
        check("rst_cause", 32'(trap_cause), 0);
        check("rst_pstall", 32'(perf_stall), 0);
        check("rst_pflush", 32'(perf_flush), 0);

        // load-use on rs1
        ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_valid = 1; id_rs1 = 5;
        #1 check("lu_rs1", 32'(ctl), 32'b1100010);
        tick();
        ex_valid = 0;
        #1 check("lu_clear", 32'(ctl), 32'h00);
        check("lu_pstall", 32'(perf_stall), 1);
        tick();
        ex_valid = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        #1 check("lu_x0", 32'(ctl), 32'h00);
        tick();
        ex_rd = 7; id_rs1 = 3; id_rs2 = 7;
        #1 check("lu_rs2", 32'(ctl), 32'b1100010);
        tick();
        check("lu_pstall2", 32'(perf_stall), 2);

        // redirect beats illegal
        clr();
        ex_valid = 1; ex_redirect = 1; id_valid = 1; id_ill = 1;
        #1 check("redir_ill", 32'(ctl), 32'b0000111);
        tick();
        check("redir_notrap", 32'(trap), 0);
        check("redir_pflush", 32'(perf_flush), 1);

        // redirect beats load-use
        id_ill = 0; ex_is_load = 1; ex_rd = 5; id_rs1 = 5;
        #1 check("redir_lu", 32'(ctl), 32'b0000111);
        tick();
        check("redir_pflush2", 32'(perf_flush), 2);

        // 3-cycle memory freeze
        clr();
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("frz_%0d", i), 32'(ctl), 32'b1111000);
            tick();
        end
        mem_ready = 1;
        #1 check("frz_rel", 32'(ctl), 32'h00);
        tick();
        check("frz_pstall", 32'(perf_stall), 5);
        check("frz_notrap", 32'(trap), 0);

        // freeze holds a redirect until release
        mem_ready = 0; ex_valid = 1; ex_redirect = 1;
        #1 check("frz_redir", 32'(ctl), 32'b1111000);
        tick();
        check("frz_redir_pf", 32'(perf_flush), 2);
        mem_ready = 1;
        #1 check("frz_redir_rel", 32'(ctl), 32'b0000111);
        tick();
        check("frz_redir_pf2", 32'(perf_flush), 3);
        check("frz_redir_ps", 32'(perf_stall), 6);

        // perf_stall saturation
        clr();
        ex_valid = 1; ex_is_load = 1; ex_rd = 9; id_valid = 1; id_rs2 = 9;
        for (int i = 0; i < 12; i++) tick();
        check("sat_pstall", 32'(perf_stall), 15);

        // memory timeout
        clr();
        mem_req = 1;
        for (int i = 0; i < TO; i++) tick();
        check("to_pre", 32'(trap), 0);
        #1 check("to_pre_ctl", 32'(ctl), 32'b1111000);
        tick();
        check("to_trap", 32'(trap), 1);
        check("to_cause", 32'(trap_cause), 2);
        #1 check("trap_frz_ctl", 32'(ctl), 32'b1111110);
        mem_ready = 1;
        #1 check("trap_ctl", 32'(ctl), 32'b1100110);
        id_valid = 1; id_ill = 1;
        tick(); tick();
        check("trap_sticky", 32'(trap), 1);
        check("cause_sticky", 32'(trap_cause), 2);

        // reset leaves trap
        clr();
        reset = 1;
        #1 check("rst2_ctl", 32'(ctl), 32'h00);
        tick();
        reset = 0;
        #1 check("rst2_trap", 32'(trap), 0);
        check("rst2_cause", 32'(trap_cause), 0);
        check("rst2_ctl2", 32'(ctl), 32'h00);
        check("rst2_pstall", 32'(perf_stall), 0);

        // illegal instruction trap
        id_valid = 1; id_ill = 1;
        #1 check("ill_ctl", 32'(ctl), 32'b1000010);
        check("ill_notrap", 32'(trap), 0);
        tick();
        check("ill_trap", 32'(trap), 1);
        check("ill_cause", 32'(trap_cause), 1);
        check("ill_pstall", 32'(perf_stall), 1);
        reset = 1;
        tick();
        reset = 0; clr();
        #1 check("ill_rst", 32'({trap, trap_cause, ctl}), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
